// File: rtl/generic_fir_pkg.sv
// generic_fir_pkg
//   Shared defaults and types for the generic_fir block-processing FIR filter.
//   DEF_NTAPS / DEF_IW / DEF_TW / DEF_OW : default maximum tap count and
//                                          sample / tap / result widths
//   PRODUCT_W                            : width of one sample x tap product
//   tap_array_t                          : packed tap load array, entry
//                                          DEF_NTAPS is reserved
package generic_fir_pkg;

    localparam int unsigned DEF_NTAPS = 8;
    localparam int unsigned DEF_IW    = 12;
    localparam int unsigned DEF_TW    = DEF_IW;
    localparam int unsigned DEF_OW    = 2 * DEF_IW + 7;
    localparam int unsigned PRODUCT_W = DEF_IW + DEF_TW;

    typedef logic [DEF_NTAPS:0][DEF_TW-1:0] tap_array_t;

endpackage

// File: rtl/generic_fir_ctrl.sv
// generic_fir_ctrl
//   Block sequencing for generic_fir: counts results (cnt) and accepted
//   input samples (scnt), decides when a step is accepted, and generates
//   the registered valid flags and the clean-pipeline request.
//   Ports:
//     clk, reset     : clock, synchronous active-high reset
//     ce             : sample enable from upstream
//     len            : input block length L
//     ntaps          : active tap count N (already clamped, >= 1)
//     accept         : this cycle is an accepted step
//     take_sample    : the accepted step consumes i_sample (else zero-fill)
//     cfg_open       : tap count may be reconfigured (idle or block done)
//     valid_first    : registered pulse with the first result of a block
//     valid_result   : registered, result updated this cycle
//     clean_pip      : block active, upstream must keep clocking ce
module generic_fir_ctrl #(
    parameter int unsigned NW = 4,
    parameter int unsigned CW = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic [15:0]   len,
    input  logic [NW-1:0] ntaps,
    output logic          accept,
    output logic          take_sample,
    output logic          cfg_open,
    output logic          valid_first,
    output logic          valid_result,
    output logic          clean_pip
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] last;
    logic [15:0]   scnt;
    logic          active;

    // Full convolution length L+N-1; only meaningful while len != 0.
    assign last        = CW'(len) + CW'(ntaps) - CW'(1);
    assign active      = (len != 16'd0) && (cnt < last);
    assign accept      = ce && active;
    assign take_sample = (scnt < len);
    assign cfg_open    = (cnt == '0) || !active;
    assign clean_pip   = active;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            scnt         <= '0;
            valid_first  <= 1'b0;
            valid_result <= 1'b0;
        end else begin
            valid_result <= accept;
            valid_first  <= accept && (cnt == '0);
            if (accept) begin
                cnt <= cnt + CW'(1);
                if (take_sample) begin
                    scnt <= scnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/generic_fir.sv
// generic_fir
//   Runtime-configurable direct-form FIR for block processing. Convolves a
//   block of L = i_output_lenght samples with N taps and emits all L+N-1
//   results; inputs past the block are zero-filled so the pipeline flushes.
//   Optional feature macro: GENERIC_FIR_NTAPS_CFG_EN
//     defined   : tap count N taken from i_ntaps when i_ntaps_en is high and
//                 no block is in progress (clamped to 1..NTAPS)
//     undefined : N fixed at NTAPS, i_ntaps / i_ntaps_en ignored
//   Ports:
//     i_clk, i_reset   : clock, synchronous active-high reset
//     i_ce             : sample enable; accepted while o_clean_pip is high
//     i_sample         : signed input sample
//     i_tap_wr         : level, load taps from i_new_tap every cycle
//     i_new_tap        : tap array, entry k multiplies x[n-k], entry NTAPS unused
//     i_ntaps          : requested active tap count
//     i_ntaps_en       : strobe to latch i_ntaps
//     i_output_lenght  : input block length L (0 disables the block)
//     o_result         : signed filter output, 1-cycle latency
//     o_valid_first    : pulse with the first result of a block
//     o_valid_result   : o_result updated this cycle
//     o_clean_pip      : block active, keep supplying i_ce
module generic_fir
    import generic_fir_pkg::*;
#(
    parameter int unsigned NTAPS = DEF_NTAPS,
    parameter int unsigned IW    = DEF_IW,
    parameter int unsigned TW    = IW,
    parameter int unsigned OW    = 2 * IW + 7
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_ce,
    input  logic signed [IW-1:0]   i_sample,
    input  logic                   i_tap_wr,
    input  logic [NTAPS:0][TW-1:0] i_new_tap,
    input  logic [3:0]             i_ntaps,
    input  logic                   i_ntaps_en,
    input  logic [15:0]            i_output_lenght,
    output logic signed [OW-1:0]   o_result,
    output logic                   o_valid_first,
    output logic                   o_valid_result,
    output logic                   o_clean_pip
);

    localparam int unsigned PW = IW + TW;
    localparam int unsigned NW = $clog2(NTAPS + 1);
    localparam int unsigned CW = 17;

    logic signed [TW-1:0] h [NTAPS];
    logic signed [IW-1:0] d [NTAPS-1];
    logic signed [IW-1:0] t [NTAPS];
    logic signed [IW-1:0] x_eff;
    logic signed [PW-1:0] prod;
    logic signed [OW-1:0] acc;
    logic [NW-1:0]        ntaps_q;
    logic                 accept;
    logic                 take_sample;
    logic                 cfg_open;

    generic_fir_ctrl #(
        .NW (NW),
        .CW (CW)
    ) u_ctrl (
        .clk          (i_clk),
        .reset        (i_reset),
        .ce           (i_ce),
        .len          (i_output_lenght),
        .ntaps        (ntaps_q),
        .accept       (accept),
        .take_sample  (take_sample),
        .cfg_open     (cfg_open),
        .valid_first  (o_valid_first),
        .valid_result (o_valid_result),
        .clean_pip    (o_clean_pip)
    );

`ifdef GENERIC_FIR_NTAPS_CFG_EN
    logic [NW-1:0] ntaps_clamped;
    logic          unused_bits;

    always_comb begin
        if (i_ntaps == 4'd0) begin
            ntaps_clamped = NW'(1);
        end else if (32'(i_ntaps) > NTAPS) begin
            ntaps_clamped = NW'(NTAPS);
        end else begin
            ntaps_clamped = NW'(i_ntaps);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ntaps_q <= NW'(NTAPS);
        end else if (i_ntaps_en && cfg_open) begin
            ntaps_q <= ntaps_clamped;
        end
    end

    assign unused_bits = ^i_new_tap[NTAPS];
`else
    logic unused_bits;

    assign ntaps_q     = NW'(NTAPS);
    assign unused_bits = ^{i_new_tap[NTAPS], i_ntaps, i_ntaps_en, cfg_open};
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned k = 0; k < NTAPS; k++) begin
                h[k] <= '0;
            end
        end else if (i_tap_wr) begin
            for (int unsigned k = 0; k < NTAPS; k++) begin
                h[k] <= i_new_tap[k];
            end
        end
    end

    // Zero-fill once the whole block has been consumed so the pipe drains.
    assign x_eff = take_sample ? i_sample : '0;

    always_comb begin
        t[0] = x_eff;
        for (int unsigned k = 1; k < NTAPS; k++) begin
            t[k] = d[k-1];
        end
    end

    // Taps at index >= N are masked out of the sum rather than zeroed in h.
    always_comb begin
        acc  = '0;
        prod = '0;
        for (int unsigned k = 0; k < NTAPS; k++) begin
            prod = PW'(h[k]) * PW'(t[k]);
            if (k < 32'(ntaps_q)) begin
                acc = acc + {{(OW-PW){prod[PW-1]}}, prod};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_result <= '0;
            for (int unsigned k = 0; k < NTAPS - 1; k++) begin
                d[k] <= '0;
            end
        end else if (accept) begin
            o_result <= acc;
            d[0]     <= x_eff;
            for (int unsigned k = 1; k < NTAPS - 1; k++) begin
                d[k] <= d[k-1];
            end
        end
    end

endmodule

// File: tb/tb_generic_fir.sv
module tb_generic_fir;
    import generic_fir_pkg::*;

    localparam int NT = DEF_NTAPS;
    localparam int IW = DEF_IW;
    localparam int OW = DEF_OW;
`ifdef GENERIC_FIR_NTAPS_CFG_EN
    localparam int N5 = 5;
    localparam int N0 = 1;
`else
    localparam int N5 = NT;
    localparam int N0 = NT;
`endif

    logic                 i_clk;
    logic                 i_reset;
    logic                 i_ce;
    logic signed [IW-1:0] i_sample;
    logic                 i_tap_wr;
    tap_array_t           i_new_tap;
    logic [3:0]           i_ntaps;
    logic                 i_ntaps_en;
    logic [15:0]          i_output_lenght;
    logic signed [OW-1:0] o_result;
    logic                 o_valid_first;
    logic                 o_valid_result;
    logic                 o_clean_pip;

    generic_fir #(
        .NTAPS (DEF_NTAPS),
        .IW    (DEF_IW),
        .TW    (DEF_TW),
        .OW    (DEF_OW)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_ce            (i_ce),
        .i_sample        (i_sample),
        .i_tap_wr        (i_tap_wr),
        .i_new_tap       (i_new_tap),
        .i_ntaps         (i_ntaps),
        .i_ntaps_en      (i_ntaps_en),
        .i_output_lenght (i_output_lenght),
        .o_result        (o_result),
        .o_valid_first   (o_valid_first),
        .o_valid_result  (o_valid_result),
        .o_clean_pip     (o_clean_pip)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic          ce;
        logic [IW-1:0] smp;
        longint        res;
        logic          vr;
        logic          vf;
        logic          pip;
    } vec_t;

    vec_t       vecs[$];
    int         n_checks = 0;
    int         n_fails  = 0;
    tap_array_t ramp_taps;
    tap_array_t neg_taps;

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input logic ce, input logic [IW-1:0] smp);
        i_ce     = ce;
        i_sample = smp;
        @(posedge i_clk);
        #1;
        i_ce = 1'b0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step(1'b0, '0);
        i_reset = 1'b0;
    endtask

    task automatic load(input int n, input tap_array_t tv);
        i_tap_wr   = 1'b1;
        i_ntaps    = 4'(n);
        i_ntaps_en = 1'b1;
        i_new_tap  = tv;
        step(1'b0, '0);
        i_tap_wr   = 1'b0;
        i_ntaps_en = 1'b0;
        i_new_tap  = '1;
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        chk({tag, " result"}, longint'(o_result), v.res);
        chk({tag, " valid_result"}, longint'(o_valid_result), longint'(v.vr));
        chk({tag, " valid_first"}, longint'(o_valid_first), longint'(v.vf));
        chk({tag, " clean_pip"}, longint'(o_clean_pip), longint'(v.pip));
    endtask

    task automatic run_vecs(input string tag, input bit midcfg);
        foreach (vecs[i]) begin
            if (midcfg && i == 1) begin
                i_ntaps    = 4'd2;
                i_ntaps_en = 1'b1;
            end else begin
                i_ntaps_en = 1'b0;
            end
            step(vecs[i].ce, vecs[i].smp);
            check_outputs($sformatf("%s[%0d]", tag, i), vecs[i]);
        end
        i_ntaps_en = 1'b0;
    endtask

    // Impulse 1,0 against taps 1..8: results 1..N then 0, then block done.
    task automatic build_impulse();
        vecs.delete();
        for (int j = 0; j <= N5; j++) begin
            vecs.push_back('{ce: 1'b1, smp: (j == 0) ? 12'd1 : 12'd0,
                             res: (j < N5) ? longint'(j + 1) : 0,
                             vr: 1'b1, vf: (j == 0), pip: (j < N5)});
        end
        vecs.push_back('{ce: 1'b1, smp: 12'h7FF, res: 0, vr: 1'b0, vf: 1'b0, pip: 1'b0});
        vecs.push_back('{ce: 1'b1, smp: 'x, res: 0, vr: 1'b0, vf: 1'b0, pip: 1'b0});
    endtask

    task automatic build_gaps();
        vecs.delete();
        for (int j = 0; j <= N5; j++) begin
            longint r;
            r = (j < N5) ? longint'(j + 1) : 0;
            vecs.push_back('{ce: 1'b1, smp: (j == 0) ? 12'd1 : 12'd0,
                             res: r, vr: 1'b1, vf: (j == 0), pip: (j < N5)});
            if (j < N5) begin
                for (int g = 0; g < 2; g++) begin
                    vecs.push_back('{ce: 1'b0, smp: 12'(j * 37 + g + 5), res: r,
                                     vr: 1'b0, vf: 1'b0, pip: 1'b1});
                end
            end
        end
    endtask

    initial begin
        i_reset         = 1'b0;
        i_ce            = 1'b0;
        i_sample        = '0;
        i_tap_wr        = 1'b0;
        i_new_tap       = '0;
        i_ntaps         = 4'd0;
        i_ntaps_en      = 1'b0;
        i_output_lenght = 16'd2;
        for (int k = 0; k < NT; k++) begin
            ramp_taps[k] = 12'(k + 1);
            neg_taps[k]  = 12'h800;
        end
        ramp_taps[NT] = 12'hABC;
        neg_taps[NT]  = 12'h123;

        // Reset state, and L=0 blocks everything.
        do_reset();
        check_outputs("reset", '{ce: 1'b0, smp: '0, res: 0, vr: 1'b0, vf: 1'b0, pip: 1'b1});
        i_output_lenght = 16'd0;
        #1;
        chk("len0 clean_pip", longint'(o_clean_pip), 0);
        step(1'b1, 12'd9);
        chk("len0 no accept", longint'(o_valid_result), 0);
        i_output_lenght = 16'd2;
        #1;
        chk("len2 clean_pip idle", longint'(o_clean_pip), 1);

        // Impulse, N=5, L=2.
        load(5, ramp_taps);
        build_impulse();
        run_vecs("impulse", 1'b0);

        // Full length, N=8, L=1.
        do_reset();
        i_output_lenght = 16'd1;
        load(8, ramp_taps);
        for (int j = 0; j < NT; j++) begin
            step(1'b1, 12'd1);
            chk($sformatf("full[%0d] result", j), longint'(o_result), longint'(j + 1));
            chk($sformatf("full[%0d] clean_pip", j), longint'(o_clean_pip), (j < NT - 1) ? 1 : 0);
        end

        // Extremes: all taps and samples -2048, zero-fill must ignore late samples.
        do_reset();
        i_output_lenght = 16'd8;
        load(8, neg_taps);
        for (int j = 0; j < 2 * NT - 1; j++) begin
            longint ov;
            ov = (j < NT) ? longint'(j + 1) : longint'(2 * NT - 1 - j);
            step(1'b1, 12'h800);
            chk($sformatf("extreme[%0d] result", j), longint'(o_result), ov * 4194304);
        end
        chk("extreme done", longint'(o_clean_pip), 0);

        // i_ce gaps.
        do_reset();
        i_output_lenght = 16'd2;
        load(5, ramp_taps);
        build_gaps();
        run_vecs("gaps", 1'b0);

        // Reset mid-block after three results, then a fresh block.
        do_reset();
        load(5, ramp_taps);
        for (int j = 0; j < 3; j++) begin
            step(1'b1, (j == 0) ? 12'd1 : 12'd0);
            chk($sformatf("premid[%0d] result", j), longint'(o_result), longint'(j + 1));
        end
        i_reset = 1'b1;
        step(1'b1, 12'd1);
        i_reset = 1'b0;
        check_outputs("midreset", '{ce: 1'b0, smp: '0, res: 0, vr: 1'b0, vf: 1'b0, pip: 1'b1});
        load(5, ramp_taps);
        build_impulse();
        run_vecs("after_reset", 1'b0);

        // ntaps = 0 clamps up to one tap.
        do_reset();
        i_output_lenght = 16'd1;
        load(0, ramp_taps);
        for (int j = 0; j < NT; j++) begin
            step(1'b1, 12'd3);
            chk($sformatf("ntaps0[%0d] result", j), longint'(o_result),
                3 * longint'((j < N0) ? j + 1 : N0));
            chk($sformatf("ntaps0[%0d] valid_result", j), longint'(o_valid_result), (j < N0) ? 1 : 0);
            chk($sformatf("ntaps0[%0d] clean_pip", j), longint'(o_clean_pip), (j < N0 - 1) ? 1 : 0);
        end

        // ntaps = 12 clamps down to NTAPS.
        do_reset();
        load(12, ramp_taps);
        for (int j = 0; j < NT; j++) begin
            step(1'b1, 12'd3);
            chk($sformatf("ntaps12[%0d] result", j), longint'(o_result), 3 * longint'(j + 1));
            chk($sformatf("ntaps12[%0d] clean_pip", j), longint'(o_clean_pip), (j < NT - 1) ? 1 : 0);
        end

        // i_ntaps_en during an active block is ignored.
        do_reset();
        i_output_lenght = 16'd2;
        load(5, ramp_taps);
        build_impulse();
        run_vecs("midcfg", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required end of stimulus");
        $fatal(1, "timeout");
    end

endmodule
